// File: rtl/idma_legalizer_req_arbiter.sv
// Round-robin arbiter that feeds 1D requests into the iDMA legalizer
// and tracks which requester owns each in-flight transfer.
module idma_legalizer_req_arbiter #(
  parameter int unsigned NumReq    = 4,
  parameter int unsigned FifoDepth = 4,
  parameter type         idma_req_t = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  idma_req_t [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]              valid_i,
  output logic [NumReq-1:0]              ready_o,
  output idma_req_t                      leg_req_o,
  output logic                           leg_valid_o,
  input  logic                           leg_ready_i,
  input  logic                           w_last_hs_i,
  input  logic                           kill_i,
  output logic [NumReq-1:0]              done_o,
  output logic [$clog2(FifoDepth):0]     inflight_o,
  output logic                           err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic {
    ARB,
    LOCK
  } state_e;

  state_e state_q, state_d;

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] grant_q;
  logic [IdxW-1:0] grant_arb;
  logic [IdxW-1:0] grant;
  logic [IdxW-1:0] grant_nxt;

  logic [IdxW-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;

  logic full, empty;
  logic push_ok, hs, pop;

  logic [NumReq-1:0] done_d, done_q;
  logic              err_q;

  // Round-robin search: lowest offset from rr_q with valid set wins.
  always_comb begin
    int j;
    grant_arb = rr_q;
    j = 0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      j = (int'(rr_q) + i) % int'(NumReq);
      if (valid_i[j]) grant_arb = IdxW'(j);
    end
  end

  assign grant = (state_q == LOCK) ? grant_q : grant_arb;

  assign grant_nxt = (grant == IdxW'(NumReq - 1)) ? '0
                   : grant + IdxW'(1);

  assign full    = (cnt_q == CntW'(FifoDepth));
  assign empty   = (cnt_q == '0);
  assign push_ok = !full || w_last_hs_i;

  // Request path toward the legalizer; reset and kill block it at once.
  always_comb begin
    leg_valid_o = ((state_q == ARB && |valid_i) || state_q == LOCK)
                && push_ok && !kill_i && !rst_i;
    leg_req_o   = req_i[grant];
    hs          = leg_valid_o && leg_ready_i;
    ready_o     = '0;
    ready_o[grant] = hs;
  end

  assign pop = w_last_hs_i && !empty && !kill_i;

  // Grant FSM next state and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    if (kill_i) begin
      state_d = ARB;
    end else begin
      unique case (state_q)
        ARB: begin
          if (hs) begin
            rr_d = grant_nxt;
          end else if (leg_valid_o) begin
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (hs) begin
            state_d = ARB;
            rr_d    = grant_nxt;
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // FSM, pointer and locked-grant registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (state_q == ARB) grant_q <= grant_arb;
    end
  end

  // Owner storage; no reset needed, occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (hs) mem_q[wr_q] <= grant;
  end

  // Owner FIFO pointers and occupancy; kill flushes everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (kill_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (hs)  wr_q <= wr_q + PtrW'(1);
      if (pop) rd_q <= rd_q + PtrW'(1);
      unique case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // One-hot completion for the owner at the FIFO head.
  always_comb begin
    done_d = '0;
    if (pop) done_d[mem_q[rd_q]] = 1'b1;
  end

  // Registered completion and protocol-error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= '0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= w_last_hs_i && empty && !kill_i;
    end
  end

  assign done_o     = done_q;
  assign err_o      = err_q;
  assign inflight_o = cnt_q;

  // A locked requester must hold its request until it is taken.
  a_hold_valid : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (state_q == LOCK && !kill_i) |-> valid_i[grant_q]
  ) else $error("requester %0d dropped valid while locked", grant_q);

endmodule

// File: tb/tb_idma_legalizer_req_arbiter.sv
// Directed bench for idma_legalizer_req_arbiter.
// Expected values are hand-computed per step.
module tb_idma_legalizer_req_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0][7:0]  req;
  logic [3:0]       valid;
  logic [3:0]       ready;
  logic [7:0]       leg_req;
  logic             leg_valid;
  logic             leg_ready;
  logic             w_last;
  logic             kill;
  logic [3:0]       done;
  logic [2:0]       inflight;
  logic             err;

  int tests;
  int fails;

  idma_legalizer_req_arbiter #(
    .NumReq    (4),
    .FifoDepth (4),
    .idma_req_t(logic [7:0])
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .valid_i    (valid),
    .ready_o    (ready),
    .leg_req_o  (leg_req),
    .leg_valid_o(leg_valid),
    .leg_ready_i(leg_ready),
    .w_last_hs_i(w_last),
    .kill_i     (kill),
    .done_o     (done),
    .inflight_o (inflight),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and checks run 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    valid     = 4'b1111;
    leg_ready = 1'b1;
    w_last    = 1'b0;
    kill      = 1'b0;
    for (int k = 0; k < 4; k++) req[k] = 8'hA0 + 8'(k);

    step();
    step();
    #1;
    chk("rst_inflight", 32'(inflight), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_leg_valid", 32'(leg_valid), 0);
    chk("rst_ready", 32'(ready), 0);

    valid = 4'b0000;
    rst   = 1'b0;
    step();

    // Write-last with nothing in flight
    w_last = 1'b1;
    step();
    w_last = 1'b0;
    chk("err_pulse", 32'(err), 1);
    chk("err_inflight", 32'(inflight), 0);
    step();
    chk("err_clear", 32'(err), 0);

    // Full round robin, then tracker full
    valid     = 4'b1111;
    leg_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("rr_req%0d", g), 32'(leg_req), 32'(8'hA0 + 8'(g)));
      chk($sformatf("rr_rdy%0d", g), 32'(ready), 32'(4'b0001 << g));
      step();
      chk($sformatf("rr_infl%0d", g), 32'(inflight), 32'(g + 1));
    end
    #1;
    chk("full_req", 32'(leg_req), 32'hA0);
    chk("full_valid", 32'(leg_valid), 0);
    chk("full_ready", 32'(ready), 0);

    // Full: push and pop in the same cycle
    w_last = 1'b1;
    #1;
    chk("fullpp_valid", 32'(leg_valid), 1);
    chk("fullpp_ready", 32'(ready), 32'b0001);
    step();
    w_last = 1'b0;
    valid  = 4'b0000;
    chk("fullpp_infl", 32'(inflight), 4);
    chk("fullpp_done", 32'(done), 32'b0001);

    // Drain owners 1,2,3,0
    for (int p = 0; p < 4; p++) begin
      w_last = 1'b1;
      step();
      w_last = 1'b0;
      chk($sformatf("drain_done%0d", p), 32'(done),
          32'(4'b0001 << ((p + 1) % 4)));
      chk($sformatf("drain_infl%0d", p), 32'(inflight), 32'(3 - p));
    end
    step();

    // Lock on requester 2 (rr is 1)
    valid     = 4'b0100;
    leg_ready = 1'b0;
    #1;
    chk("lock_c0_valid", 32'(leg_valid), 1);
    chk("lock_c0_req", 32'(leg_req), 32'hA2);
    chk("lock_c0_ready", 32'(ready), 0);
    step();
    valid = 4'b0111;
    #1;
    chk("lock_c1_req", 32'(leg_req), 32'hA2);
    chk("lock_c1_ready", 32'(ready), 0);
    step();
    #1;
    chk("lock_c2_req", 32'(leg_req), 32'hA2);
    leg_ready = 1'b1;
    #1;
    chk("lock_hs_ready", 32'(ready), 32'b0100);
    step();
    valid = 4'b0011;
    #1;
    chk("lock_next_req", 32'(leg_req), 32'hA0);
    chk("lock_next_ready", 32'(ready), 32'b0001);
    chk("lock_infl", 32'(inflight), 1);
    step();
    valid = 4'b0000;
    chk("lock_infl2", 32'(inflight), 2);

    // Drain owners 2 then 0
    w_last = 1'b1;
    step();
    chk("d2_done", 32'(done), 32'b0100);
    step();
    w_last = 1'b0;
    chk("d0_done", 32'(done), 32'b0001);
    chk("d0_infl", 32'(inflight), 0);

    // Grants 1 and 3, then two completions
    valid = 4'b1010;
    #1;
    chk("g1_req", 32'(leg_req), 32'hA1);
    step();
    #1;
    chk("g3_req", 32'(leg_req), 32'hA3);
    step();
    valid = 4'b0000;
    chk("g13_infl", 32'(inflight), 2);
    w_last = 1'b1;
    step();
    w_last = 1'b0;
    chk("c1_done", 32'(done), 32'b0010);
    chk("c1_infl", 32'(inflight), 1);
    step();
    chk("c1_done_clr", 32'(done), 0);
    w_last = 1'b1;
    step();
    w_last = 1'b0;
    chk("c3_done", 32'(done), 32'b1000);
    chk("c3_infl", 32'(inflight), 0);

    // Two in flight, then kill with write-last
    valid = 4'b0001;
    step();
    valid = 4'b0010;
    step();
    chk("kill_pre_infl", 32'(inflight), 2);
    valid  = 4'b0100;
    kill   = 1'b1;
    w_last = 1'b1;
    #1;
    chk("kill_valid", 32'(leg_valid), 0);
    chk("kill_ready", 32'(ready), 0);
    step();
    kill   = 1'b0;
    w_last = 1'b0;
    valid  = 4'b0000;
    chk("kill_infl", 32'(inflight), 0);
    chk("kill_done", 32'(done), 0);
    chk("kill_err", 32'(err), 0);

    // rr stayed at 2; hold requester 2 waiting to enter LOCK
    valid     = 4'b1111;
    leg_ready = 1'b0;
    #1;
    chk("post_kill_req", 32'(leg_req), 32'hA2);
    step();
    rst = 1'b1;
    #1;
    chk("rst_lock_valid", 32'(leg_valid), 0);
    chk("rst_lock_ready", 32'(ready), 0);
    step();
    rst       = 1'b0;
    leg_ready = 1'b1;
    #1;
    chk("first_grant", 32'(leg_req), 32'hA0);
    chk("first_ready", 32'(ready), 32'b0001);
    step();
    valid = 4'b0000;
    step();
    chk("final_done", 32'(done), 0);
    chk("final_infl", 32'(inflight), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
